mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// - Shares the single-port 4KB system memory between the RV32I instruction-fetch port (read-only)
//   and the load/store port (read/write, byte strobes).
// - Sits between the core and the memory: drives we/addr/din/wstrb, consumes dout (1-cycle read latency).
// - Fixed data priority with a starvation guard for fetch; back-to-back issue, no bubbles.
// PARAMETERS
// - ADDR_W      10  memory word-address width; byte address bits [ADDR_W+1:2] are forwarded
// - MAX_DSTREAK 4   max consecutive data grants while fetch waits before fetch is forced (1..15)
// PORTS
// - clk         in   1       system clock
// - rst         in   1       synchronous reset, active high
// - i_req       in   1       fetch request; addr held stable until i_gnt
// - i_addr      in   32      fetch byte address
// - i_gnt       out  1       fetch granted this cycle (combinational)
// - i_rvalid    out  1       fetch read data valid (cycle after i_gnt)
// - i_rdata     out  32      fetch read data
// - d_req       in   1       data request; d_* held stable until d_gnt
// - d_we        in   1       1 = store, 0 = load
// - d_addr      in   32      data byte address
// - d_wdata     in   32      store data
// - d_wstrb     in   4       store byte enables
// - d_gnt       out  1       data granted this cycle (combinational)
// - d_rvalid    out  1       load data valid (cycle after a load grant; never for stores)
// - d_rdata     out  32      load data
// - mem_we      out  1       memory write enable
// - mem_addr    out  ADDR_W  memory word address
// - mem_din     out  32      memory write data
// - mem_wstrb   out  4       memory byte enables
// - mem_dout    in   32      memory read data (registered address, valid 1 cycle after issue)
// BEHAVIOUR
// - Arbitration (combinational, each cycle):
//   only one req -> that port granted; both -> d granted unless streak==MAX_DSTREAK, then i granted.
// - streak (4b reg): +1 when d granted while i_req=1; cleared when i granted or i_req=0. Saturates at MAX_DSTREAK.
// - Memory drive: mem_addr = granted addr[ADDR_W+1:2]; mem_we = d_gnt & d_we;
//   mem_din = d_wdata, mem_wstrb = d_wstrb. With no grant: mem_we=0, mem_wstrb=0, mem_addr holds last value.
// - Response owner reg resp[1:0] ∈ {NONE, IFETCH, DLOAD}, loaded every cycle from this cycle's grant
//   (store grant -> NONE).
//   i_rvalid = (resp==IFETCH); d_rvalid = (resp==DLOAD); i_rdata = d_rdata = mem_dout.
// - Latency: grant same cycle as req (no other contender); read data exactly 1 cycle later; stores retire on grant.
// - Pipelining: a new grant may issue in the same cycle a previous read's rvalid is high; full throughput 1 access/cycle.
// - Store followed by load to same word: load in next cycle returns new data (memory write-first ordering by cycle).
// - Requester dropping req before gnt: legal, no side effects. Changing addr while req high and ungranted: legal,
//   latest value used at grant.
// - Reset (any cycle, incl. mid-read): resp=NONE, streak=0; i_rvalid=d_rvalid=0 next cycle;
//   in-flight read response is discarded; mem_we=0 and all grants 0 while rst=1; mem_addr resets to 0.
// - Out-of-range addresses (bits above ADDR_W+1 set) are truncated, not flagged; MMIO decode stays in the memory.
// CONFIGURATION
// - MEM_ARB_PERF_EN defined: adds outputs perf_conflicts[31:0] (cycles with i_req & d_req) and perf_forced[31:0]
//   (fetch grants forced by streak guard); both clear on rst, wrap modulo 2^32.
// - Not defined: ports and counters absent; arbitration identical.
// TESTING
// - i_req only, addr 0x0000_0008 -> i_gnt same cycle, mem_addr=2, i_rvalid next cycle, i_rdata=ram[2].
// - d store 0xDEADBEEF wstrb=4'b0011 @0x10 then load @0x10 -> mem_we 1 cycle; load returns 0x????BEEF with upper
//   half unchanged; d_rvalid 1 cycle after load grant, never after store.
// - i_req and d_req held high 12 cycles, MAX_DSTREAK=4 -> grant pattern DDDDI repeating; no i starvation;
//   perf_forced=2, perf_conflicts=12.
// - Alternating i/d reads every cycle -> one grant per cycle, each rvalid routed to the correct port, no bubbles.
// - rst asserted the cycle after a d load grant -> d_rvalid stays 0, streak=0, mem_we=0; normal operation resumes
//   the cycle after rst drops.
// - d_req toggled low before grant while i wins by guard -> no store issued, mem_we stays 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load/store and memory-side signals of the memory arbiter.
interface mem_arbiter_if #(parameter int ADDR_W = 10);
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_wstrb;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_dout;
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_dout,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, mem_we, mem_addr, mem_din, mem_wstrb
  );
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_dout,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, mem_we, mem_addr, mem_din, mem_wstrb
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares single-port memory between fetch and load/store, data priority with fetch starvation guard.
// Defining MEM_ARB_PERF_EN adds perf_conflicts_o / perf_forced_o counters.
module mem_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int MAX_DSTREAK = 4
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_conflicts_o,
  output logic [31:0] perf_forced_o
`endif
);
  typedef enum logic [1:0] {NONE, IFETCH, DLOAD} resp_e;
  resp_e             resp_q, resp_d;
  logic [3:0]        streak_q, streak_d;
  logic [ADDR_W-1:0] addr_q;
  logic              force_i;
  logic              unused_addr;
  assign unused_addr = ^{bus.i_addr[31:ADDR_W+2], bus.i_addr[1:0], bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0]};
  always_comb begin
    force_i = bus.i_req & bus.d_req & (streak_q == 4'(MAX_DSTREAK));
    bus.i_gnt = !rst & bus.i_req & (!bus.d_req | force_i);
    bus.d_gnt = !rst & bus.d_req & !force_i;
    bus.mem_addr = bus.i_gnt ? bus.i_addr[ADDR_W+1:2] : bus.d_gnt ? bus.d_addr[ADDR_W+1:2] : addr_q;
    bus.mem_we = bus.d_gnt & bus.d_we;
    bus.mem_din = bus.d_wdata;
    bus.mem_wstrb = bus.d_gnt ? bus.d_wstrb : 4'b0;
    resp_d = bus.i_gnt ? IFETCH : (bus.d_gnt & !bus.d_we) ? DLOAD : NONE;
    streak_d = (bus.i_gnt | !bus.i_req) ? 4'd0 :
               (bus.d_gnt && streak_q != 4'(MAX_DSTREAK)) ? streak_q + 4'd1 : streak_q;
    // gating with rst drops a read that was in flight when reset arrived
    bus.i_rvalid = !rst & (resp_q == IFETCH);
    bus.d_rvalid = !rst & (resp_q == DLOAD);
    bus.i_rdata = bus.mem_dout;
    bus.d_rdata = bus.mem_dout;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q   <= NONE;
      streak_q <= 4'd0;
      addr_q   <= '0;
    end else begin
      resp_q   <= resp_d;
      streak_q <= streak_d;
      addr_q   <= bus.mem_addr;
    end
  end
`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflicts_o <= '0;
      perf_forced_o    <= '0;
    end else begin
      perf_conflicts_o <= perf_conflicts_o + {31'd0, bus.i_req & bus.d_req};
      perf_forced_o    <= perf_forced_o + {31'd0, bus.i_gnt & force_i};
    end
  end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors against a behavioural 1-cycle-latency RAM.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] ram [0:1023];
  mem_arbiter_if #(.ADDR_W(10)) bus ();
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_conflicts, perf_forced;
`endif
  mem_arbiter #(.ADDR_W(10), .MAX_DSTREAK(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_conflicts_o(perf_conflicts),
    .perf_forced_o(perf_forced)
`endif
  );
  always #5 clk = ~clk;
  initial for (int i = 0; i < 1024; i++) ram[i] = 32'h1000_0000 + i;
  always @(posedge clk) begin
    if (bus.mem_we)
      for (int b = 0; b < 4; b++)
        if (bus.mem_wstrb[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_din[8*b +: 8];
    bus.mem_dout <= ram[bus.mem_addr];
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic r, input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd, input logic [3:0] ds);
    @(posedge clk);
    #1;
    rst = r;
    bus.i_req = ir;
    bus.i_addr = ia;
    bus.d_req = dr;
    bus.d_we = dw;
    bus.d_addr = da;
    bus.d_wdata = dd;
    bus.d_wstrb = ds;
    #1;
  endtask
  initial begin
    logic prev_i;
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.d_wstrb = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_i_gnt", 32'(bus.i_gnt), 0);
    check("rst_d_gnt", 32'(bus.d_gnt), 0);
    check("rst_mem_we", 32'(bus.mem_we), 0);
    check("rst_i_rvalid", 32'(bus.i_rvalid), 0);
    check("rst_d_rvalid", 32'(bus.d_rvalid), 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    // single fetch
    drive(0, 1, 32'h8, 0, 0, 0, 0, 0);
    check("if_gnt", 32'(bus.i_gnt), 1);
    check("if_d_gnt", 32'(bus.d_gnt), 0);
    check("if_mem_addr", 32'(bus.mem_addr), 2);
    check("if_mem_we", 32'(bus.mem_we), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("if_rvalid", 32'(bus.i_rvalid), 1);
    check("if_rdata", bus.i_rdata, 32'h1000_0002);
    check("if_d_rvalid", 32'(bus.d_rvalid), 0);
    check("if_addr_hold", 32'(bus.mem_addr), 2);
    check("idle_wstrb", 32'(bus.mem_wstrb), 0);
    // partial store then load of the same word
    drive(0, 0, 0, 1, 1, 32'h10, 32'hDEAD_BEEF, 4'b0011);
    check("st_gnt", 32'(bus.d_gnt), 1);
    check("st_mem_we", 32'(bus.mem_we), 1);
    check("st_mem_addr", 32'(bus.mem_addr), 4);
    check("st_wstrb", 32'(bus.mem_wstrb), 3);
    check("st_din", bus.mem_din, 32'hDEAD_BEEF);
    drive(0, 0, 0, 1, 0, 32'h10, 0, 0);
    check("ld_gnt", 32'(bus.d_gnt), 1);
    check("ld_mem_we", 32'(bus.mem_we), 0);
    check("st_no_rvalid", 32'(bus.d_rvalid), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("ld_rvalid", 32'(bus.d_rvalid), 1);
    check("ld_rdata", bus.d_rdata, 32'h1000_BEEF);
    check("ld_i_rvalid", 32'(bus.i_rvalid), 0);
    // sustained contention: DDDDI repeating
    prev_i = 0;
    for (int k = 0; k < 12; k++) begin
      logic exp_i;
      exp_i = (k % 5) == 4;
      drive(0, 1, 32'h4, 1, 0, 32'h20, 0, 0);
      check($sformatf("cont_i_gnt%0d", k), 32'(bus.i_gnt), 32'(exp_i));
      check($sformatf("cont_d_gnt%0d", k), 32'(bus.d_gnt), 32'(!exp_i));
      check($sformatf("cont_addr%0d", k), 32'(bus.mem_addr), exp_i ? 32'd1 : 32'd8);
      if (k > 0) begin
        check($sformatf("cont_i_rv%0d", k), 32'(bus.i_rvalid), 32'(prev_i));
        check($sformatf("cont_d_rv%0d", k), 32'(bus.d_rvalid), 32'(!prev_i));
        check($sformatf("cont_rdata%0d", k), bus.d_rdata, prev_i ? 32'h1000_0001 : 32'h1000_0008);
      end
      prev_i = exp_i;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("cont_last_rv", 32'(bus.d_rvalid), 1);
`ifdef MEM_ARB_PERF_EN
    check("perf_conflicts", perf_conflicts, 12);
    check("perf_forced", perf_forced, 2);
`endif
    // alternating single requesters, one access per cycle
    for (int k = 0; k < 6; k++) begin
      logic [31:0] a;
      a = 32'(4 * (k + 8));
      if (k % 2 == 0) drive(0, 1, a, 0, 0, 0, 0, 0);
      else drive(0, 0, 0, 1, 0, a, 0, 0);
      check($sformatf("alt_i_gnt%0d", k), 32'(bus.i_gnt), 32'(k % 2 == 0));
      check($sformatf("alt_d_gnt%0d", k), 32'(bus.d_gnt), 32'(k % 2 == 1));
      check($sformatf("alt_addr%0d", k), 32'(bus.mem_addr), 32'(k + 8));
      if (k > 0) begin
        check($sformatf("alt_i_rv%0d", k), 32'(bus.i_rvalid), 32'(k % 2 == 1));
        check($sformatf("alt_d_rv%0d", k), 32'(bus.d_rvalid), 32'(k % 2 == 0));
        check($sformatf("alt_rdata%0d", k), bus.i_rdata, 32'h1000_0000 + 32'(k + 7));
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("alt_last_rv", 32'(bus.d_rvalid), 1);
    check("alt_last_rdata", bus.d_rdata, 32'h1000_000D);
    // reset right after a load grant, with streak built up
    drive(0, 1, 32'h4, 1, 0, 32'h20, 0, 0);
    check("pre_rst_gnt0", 32'(bus.d_gnt), 1);
    drive(0, 1, 32'h4, 1, 0, 32'h20, 0, 0);
    check("pre_rst_gnt1", 32'(bus.d_gnt), 1);
    drive(1, 1, 32'h4, 1, 1, 32'h20, 32'h55, 4'hF);
    check("mid_rst_i_gnt", 32'(bus.i_gnt), 0);
    check("mid_rst_d_gnt", 32'(bus.d_gnt), 0);
    check("mid_rst_we", 32'(bus.mem_we), 0);
    check("mid_rst_d_rv", 32'(bus.d_rvalid), 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("mid_rst_addr", 32'(bus.mem_addr), 0);
    check("mid_rst_d_rv2", 32'(bus.d_rvalid), 0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 32'h4, 1, 0, 32'h20, 0, 0);
      check($sformatf("post_rst_i_gnt%0d", k), 32'(bus.i_gnt), 32'(k == 4));
      if (k == 0) check("post_rst_d_rv", 32'(bus.d_rvalid), 0);
    end
    // store request withdrawn while fetch wins by the guard
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 32'h4, 1, 0, 32'h20, 0, 0);
      check($sformatf("guard_d_gnt%0d", k), 32'(bus.d_gnt), 1);
    end
    drive(0, 1, 32'h4, 1, 1, 32'h30, 32'hFFFF_FFFF, 4'hF);
    check("guard_i_gnt", 32'(bus.i_gnt), 1);
    check("guard_d_gnt", 32'(bus.d_gnt), 0);
    check("guard_we", 32'(bus.mem_we), 0);
    drive(0, 0, 0, 0, 1, 32'h30, 32'hFFFF_FFFF, 4'hF);
    check("drop_we", 32'(bus.mem_we), 0);
    check("drop_d_gnt", 32'(bus.d_gnt), 0);
    drive(0, 0, 0, 1, 0, 32'h30, 0, 0);
    check("drop_ld_gnt", 32'(bus.d_gnt), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("drop_rdata", bus.d_rdata, 32'h1000_000C);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
